// File: rtl/snes_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snes_rom_pkg
// Description : Shared types and helpers for the SNES ROM/SRAM responder.
//               Holds the responder state encoding, external memory bus
//               widths and the byte-lane select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package snes_rom_pkg;

   localparam int MEM_AW = 23;   // external word address width
   localparam int MEM_DW = 16;   // external data bus width

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SRD  = 3'd1,   // SNES read cycle
      ST_SWR  = 3'd2,   // SNES write cycle (save RAM)
      ST_MRD  = 3'd3,   // MCU read cycle
      ST_MWR  = 3'd4    // MCU write cycle
   } state_e;

   // Pick the addressed byte out of a 16-bit memory word.
   // hi = 1 selects [15:8] (odd byte address), hi = 0 selects [7:0].
   function automatic logic [7:0] lane_byte(input logic [MEM_DW-1:0] word,
                                            input logic              hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/snes_rom_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : snes_rom_responder_if
// Description : Request, response and external memory signals of the
//               SNES ROM/SRAM responder.
//               slave  : responder view (takes requests, drives memory pins)
//               master : environment view (issues requests, models memory)
//               Ports  : SNES request/data, MCU request/data, MEM_* pins, BUSY
// Revision    : 1.0 - initial release
// ============================================================================
interface snes_rom_responder_if;
   import snes_rom_pkg::*;

   // SNES side
   logic                SNES_RD_START;
   logic                SNES_WR_END;
   logic [7:0]          SNES_DIN;
   logic [23:0]         ROM_ADDR;
   logic                ROM_HIT;
   logic                IS_WRITABLE;
   logic [7:0]          SNES_DOUT;
   logic                SNES_DVALID;
   // MCU side
   logic                MCU_RRQ;
   logic                MCU_WRQ;
   logic [23:0]         MCU_ADDR;
   logic [7:0]          MCU_DOUT;
   logic [7:0]          MCU_DIN;
   logic                MCU_RDY;
   // External memory pins
   logic [MEM_AW-1:0]   MEM_A;
   logic [MEM_DW-1:0]   MEM_DOUT;
   logic                MEM_DOE;
   logic [MEM_DW-1:0]   MEM_DIN;
   logic                MEM_CE_N;
   logic                MEM_OE_N;
   logic                MEM_WE_N;
   logic                MEM_BHE_N;
   logic                MEM_BLE_N;
   // Status
   logic                BUSY;

   modport slave (
      input  SNES_RD_START, SNES_WR_END, SNES_DIN, ROM_ADDR, ROM_HIT, IS_WRITABLE,
      input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, MEM_DIN,
      output SNES_DOUT, SNES_DVALID, MCU_DIN, MCU_RDY,
      output MEM_A, MEM_DOUT, MEM_DOE, MEM_CE_N, MEM_OE_N, MEM_WE_N,
      output MEM_BHE_N, MEM_BLE_N, BUSY
   );

   modport master (
      output SNES_RD_START, SNES_WR_END, SNES_DIN, ROM_ADDR, ROM_HIT, IS_WRITABLE,
      output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, MEM_DIN,
      input  SNES_DOUT, SNES_DVALID, MCU_DIN, MCU_RDY,
      input  MEM_A, MEM_DOUT, MEM_DOE, MEM_CE_N, MEM_OE_N, MEM_WE_N,
      input  MEM_BHE_N, MEM_BLE_N, BUSY
   );

endinterface
`default_nettype wire

// File: rtl/rom_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : rom_cycle_timer
// Description : Loadable down-counter that paces one external memory cycle.
//               Ports : clk, rst_n (async, active-low), load (start a cycle)
//                       first     - current clock is the first of the cycle
//                       last      - current clock is the final one (count 0)
//                       we_window - a middle clock whose successor still
//                                   carries the write strobe
// Revision    : 1.0 - initial release
// ============================================================================
module rom_cycle_timer #(
   parameter int CYCLE_LEN = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic first,
   output logic last,
   output logic we_window
);

   localparam logic [3:0] C_LOAD = 4'(CYCLE_LEN - 1);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // Saturates at zero so an idle responder sits with last asserted.
   always_comb begin
      if (load) begin
         count_d = C_LOAD;
      end else if (count_q != 4'd0) begin
         count_d = count_q - 4'd1;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign first     = (count_q == C_LOAD);
   assign last      = (count_q == 4'd0);
   // Counts 2..C_LOAD-1: together with 'first' these are the edges at which
   // the registered write strobe must be (re)driven low, which yields
   // CYCLE_LEN-2 low clocks with one clock of setup and one of hold.
   assign we_window = (count_q >= 4'd2) && (count_q <= (C_LOAD - 4'd1));

endmodule
`default_nettype wire

// File: rtl/snes_rom_responder.sv
`default_nettype none
// ============================================================================
// Module      : snes_rom_responder
// Description : Runs timed read/write cycles on the 16-bit external ROM/SRAM
//               bus for decoded SNES accesses, and services MCU byte requests
//               in the gaps between them.
//               Ports : CLK, RST_N (async, active-low)
//                       bus (slave) - SNES/MCU requests and responses plus the
//                                     MEM_* pins and BUSY
// Revision    : 1.0 - initial release
// ============================================================================
module snes_rom_responder
   import snes_rom_pkg::*;
#(
   parameter int CYCLE_LEN = 7
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   snes_rom_responder_if.slave  bus
);

   state_e              state_q, state_d;
   logic                gap_q, gap_d;

   logic                srd_pend_q, srd_pend_d;
   logic                swr_pend_q, swr_pend_d;
   logic                mrd_pend_q, mrd_pend_d;
   logic                mwr_pend_q, mwr_pend_d;
   logic [23:0]         srd_addr_q, srd_addr_d;
   logic [23:0]         swr_addr_q, swr_addr_d;
   logic [23:0]         mrd_addr_q, mrd_addr_d;
   logic [23:0]         mwr_addr_q, mwr_addr_d;
   logic [7:0]          swr_data_q, swr_data_d;
   logic [7:0]          mwr_data_q, mwr_data_d;

   logic [MEM_AW-1:0]   mem_a_q, mem_a_d;
   logic [MEM_DW-1:0]   mem_dout_q, mem_dout_d;
   logic                mem_doe_q, mem_doe_d;
   logic                mem_ce_n_q, mem_ce_n_d;
   logic                mem_oe_n_q, mem_oe_n_d;
   logic                mem_we_n_q, mem_we_n_d;
   logic                mem_bhe_n_q, mem_bhe_n_d;
   logic                mem_ble_n_q, mem_ble_n_d;
   logic [7:0]          snes_dout_q, snes_dout_d;
   logic                snes_dvalid_q, snes_dvalid_d;
   logic [7:0]          mcu_din_q, mcu_din_d;
   logic                mcu_rdy_q, mcu_rdy_d;
   logic                busy_q, busy_d;

   logic                srd_set, swr_set;
   logic                timer_load, t_first, t_last, t_we_window;
   logic                go, sel_write;
   state_e              sel_state;
   logic [23:0]         sel_addr;
   logic [7:0]          sel_data;

   rom_cycle_timer #(
      .CYCLE_LEN (CYCLE_LEN)
   ) u_timer (
      .clk       (CLK),
      .rst_n     (RST_N),
      .load      (timer_load),
      .first     (t_first),
      .last      (t_last),
      .we_window (t_we_window)
   );

   always_comb begin
      // A read strobe wins over a write strobe in the same clock.
      srd_set = bus.SNES_RD_START & bus.ROM_HIT;
      swr_set = bus.SNES_WR_END & bus.ROM_HIT & bus.IS_WRITABLE & ~bus.SNES_RD_START;

      state_d       = state_q;
      gap_d         = gap_q;
      srd_pend_d    = srd_pend_q;
      swr_pend_d    = swr_pend_q;
      mrd_pend_d    = mrd_pend_q;
      mwr_pend_d    = mwr_pend_q;
      srd_addr_d    = srd_addr_q;
      swr_addr_d    = swr_addr_q;
      mrd_addr_d    = mrd_addr_q;
      mwr_addr_d    = mwr_addr_q;
      swr_data_d    = swr_data_q;
      mwr_data_d    = mwr_data_q;
      mem_a_d       = mem_a_q;
      mem_dout_d    = mem_dout_q;
      mem_doe_d     = mem_doe_q;
      mem_ce_n_d    = mem_ce_n_q;
      mem_oe_n_d    = mem_oe_n_q;
      mem_we_n_d    = mem_we_n_q;
      mem_bhe_n_d   = mem_bhe_n_q;
      mem_ble_n_d   = mem_ble_n_q;
      snes_dout_d   = snes_dout_q;
      snes_dvalid_d = 1'b0;
      mcu_din_d     = mcu_din_q;
      mcu_rdy_d     = 1'b0;
      timer_load    = 1'b0;
      go            = 1'b0;
      sel_write     = 1'b0;
      sel_state     = ST_IDLE;
      sel_addr      = 24'd0;
      sel_data      = 8'd0;

      case (state_q)
         ST_IDLE: begin
            // gap_q forces one dead clock after every cycle so the strobes
            // are seen deasserted between back-to-back cycles.
            if (gap_q) begin
               gap_d = 1'b0;
            end else if (srd_pend_q) begin
               go = 1'b1; sel_state = ST_SRD; sel_addr = srd_addr_q;
               srd_pend_d = 1'b0;
            end else if (swr_pend_q) begin
               go = 1'b1; sel_state = ST_SWR; sel_addr = swr_addr_q;
               sel_data = swr_data_q; sel_write = 1'b1;
               swr_pend_d = 1'b0;
            end else if (mrd_pend_q) begin
               go = 1'b1; sel_state = ST_MRD; sel_addr = mrd_addr_q;
               mrd_pend_d = 1'b0;
            end else if (mwr_pend_q) begin
               go = 1'b1; sel_state = ST_MWR; sel_addr = mwr_addr_q;
               sel_data = mwr_data_q; sel_write = 1'b1;
               mwr_pend_d = 1'b0;
            end
         end

         default: begin
            if (t_last) begin
               state_d     = ST_IDLE;
               gap_d       = 1'b1;
               mem_ce_n_d  = 1'b1;
               mem_oe_n_d  = 1'b1;
               mem_we_n_d  = 1'b1;
               mem_bhe_n_d = 1'b1;
               mem_ble_n_d = 1'b1;
               mem_doe_d   = 1'b0;
               // The active lane is remembered by whichever enable is low.
               if (state_q == ST_SRD) begin
                  snes_dout_d   = lane_byte(bus.MEM_DIN, ~mem_bhe_n_q);
                  snes_dvalid_d = 1'b1;
               end
               if (state_q == ST_MRD) begin
                  mcu_din_d = lane_byte(bus.MEM_DIN, ~mem_bhe_n_q);
               end
               if ((state_q == ST_MRD) || (state_q == ST_MWR)) begin
                  mcu_rdy_d = 1'b1;
               end
            end else if ((state_q == ST_SWR) || (state_q == ST_MWR)) begin
               mem_we_n_d = ~(t_first | t_we_window);
            end
         end
      endcase

      if (go) begin
         state_d     = sel_state;
         timer_load  = 1'b1;
         mem_a_d     = sel_addr[23:1];
         mem_ble_n_d = sel_addr[0];
         mem_bhe_n_d = ~sel_addr[0];
         mem_ce_n_d  = 1'b0;
         mem_oe_n_d  = sel_write;
         mem_we_n_d  = 1'b1;
         mem_doe_d   = sel_write;
         if (sel_write) begin
            mem_dout_d = {sel_data, sel_data};
         end
      end

      // New requests are applied after the grant so a pulse arriving in the
      // same clock as a grant of its own kind stays pending.
      if (srd_set) begin
         srd_pend_d = 1'b1;
         srd_addr_d = bus.ROM_ADDR;
      end
      if (swr_set) begin
         swr_pend_d = 1'b1;
         swr_addr_d = bus.ROM_ADDR;
         swr_data_d = bus.SNES_DIN;
      end
      if (bus.MCU_RRQ) begin
         mrd_pend_d = 1'b1;
         mrd_addr_d = bus.MCU_ADDR;
      end
      if (bus.MCU_WRQ) begin
         mwr_pend_d = 1'b1;
         mwr_addr_d = bus.MCU_ADDR;
         mwr_data_d = bus.MCU_DOUT;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_IDLE;
         gap_q         <= 1'b0;
         srd_pend_q    <= 1'b0;
         swr_pend_q    <= 1'b0;
         mrd_pend_q    <= 1'b0;
         mwr_pend_q    <= 1'b0;
         srd_addr_q    <= 24'd0;
         swr_addr_q    <= 24'd0;
         mrd_addr_q    <= 24'd0;
         mwr_addr_q    <= 24'd0;
         swr_data_q    <= 8'd0;
         mwr_data_q    <= 8'd0;
         mem_a_q       <= '0;
         mem_dout_q    <= '0;
         mem_doe_q     <= 1'b0;
         mem_ce_n_q    <= 1'b1;
         mem_oe_n_q    <= 1'b1;
         mem_we_n_q    <= 1'b1;
         mem_bhe_n_q   <= 1'b1;
         mem_ble_n_q   <= 1'b1;
         snes_dout_q   <= 8'd0;
         snes_dvalid_q <= 1'b0;
         mcu_din_q     <= 8'd0;
         mcu_rdy_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_q         <= gap_d;
         srd_pend_q    <= srd_pend_d;
         swr_pend_q    <= swr_pend_d;
         mrd_pend_q    <= mrd_pend_d;
         mwr_pend_q    <= mwr_pend_d;
         srd_addr_q    <= srd_addr_d;
         swr_addr_q    <= swr_addr_d;
         mrd_addr_q    <= mrd_addr_d;
         mwr_addr_q    <= mwr_addr_d;
         swr_data_q    <= swr_data_d;
         mwr_data_q    <= mwr_data_d;
         mem_a_q       <= mem_a_d;
         mem_dout_q    <= mem_dout_d;
         mem_doe_q     <= mem_doe_d;
         mem_ce_n_q    <= mem_ce_n_d;
         mem_oe_n_q    <= mem_oe_n_d;
         mem_we_n_q    <= mem_we_n_d;
         mem_bhe_n_q   <= mem_bhe_n_d;
         mem_ble_n_q   <= mem_ble_n_d;
         snes_dout_q   <= snes_dout_d;
         snes_dvalid_q <= snes_dvalid_d;
         mcu_din_q     <= mcu_din_d;
         mcu_rdy_q     <= mcu_rdy_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.MEM_A       = mem_a_q;
   assign bus.MEM_DOUT    = mem_dout_q;
   assign bus.MEM_DOE     = mem_doe_q;
   assign bus.MEM_CE_N    = mem_ce_n_q;
   assign bus.MEM_OE_N    = mem_oe_n_q;
   assign bus.MEM_WE_N    = mem_we_n_q;
   assign bus.MEM_BHE_N   = mem_bhe_n_q;
   assign bus.MEM_BLE_N   = mem_ble_n_q;
   assign bus.SNES_DOUT   = snes_dout_q;
   assign bus.SNES_DVALID = snes_dvalid_q;
   assign bus.MCU_DIN     = mcu_din_q;
   assign bus.MCU_RDY     = mcu_rdy_q;
   assign bus.BUSY        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_rom_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_snes_rom_responder
// Description : Self-checking bench for snes_rom_responder. Directed requests
//               push expected read responses into queues; a monitor pops and
//               compares on every SNES_DVALID / MCU_RDY pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_rom_responder;

   localparam int CL = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   snes_rom_responder_if bus();

   snes_rom_responder #(
      .CYCLE_LEN (CL)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus.slave)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc_at;
   } exp_t;

   exp_t snes_q[$];
   exp_t mcu_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.SNES_DVALID) begin
            if (snes_q.size() == 0) begin
               check("snes_dvalid_unexpected", {31'd0, bus.SNES_DVALID}, 32'd0);
            end else begin
               e = snes_q.pop_front();
               check("snes_dout", {24'd0, bus.SNES_DOUT}, {24'd0, e.data});
               check("snes_dvalid_cycle", cyc, e.cyc_at);
            end
         end
         if (bus.MCU_RDY) begin
            if (mcu_q.size() == 0) begin
               check("mcu_rdy_unexpected", {31'd0, bus.MCU_RDY}, 32'd0);
            end else begin
               e = mcu_q.pop_front();
               check("mcu_din", {24'd0, bus.MCU_DIN}, {24'd0, e.data});
               check("mcu_rdy_cycle", cyc, e.cyc_at);
            end
         end
      end
   end

   task automatic run_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic snes_req(input logic rd, input logic wr, input logic [23:0] a,
                           input logic [7:0] d, input logic hit, input logic wable,
                           output int t);
      @(negedge clk);
      bus.ROM_ADDR = a; bus.SNES_DIN = d; bus.ROM_HIT = hit; bus.IS_WRITABLE = wable;
      bus.SNES_RD_START = rd; bus.SNES_WR_END = wr;
      t = cyc + 1;
      @(negedge clk);
      bus.SNES_RD_START = 1'b0; bus.SNES_WR_END = 1'b0;
   endtask

   task automatic mcu_req(input logic rd, input logic [23:0] a, input logic [7:0] d,
                          output int t);
      @(negedge clk);
      bus.MCU_ADDR = a; bus.MCU_DOUT = d;
      bus.MCU_RRQ = rd; bus.MCU_WRQ = ~rd;
      t = cyc + 1;
      @(negedge clk);
      bus.MCU_RRQ = 1'b0; bus.MCU_WRQ = 1'b0;
   endtask

   function automatic logic [8:0] strobes();
      return {bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N, bus.MEM_BHE_N, bus.MEM_BLE_N,
              bus.MEM_DOE, bus.BUSY, bus.SNES_DVALID, bus.MCU_RDY};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t2, cnt, cnt2, first_low;

      bus.SNES_RD_START = 1'b0; bus.SNES_WR_END = 1'b0; bus.SNES_DIN = 8'd0;
      bus.ROM_ADDR = 24'd0; bus.ROM_HIT = 1'b0; bus.IS_WRITABLE = 1'b0;
      bus.MCU_RRQ = 1'b0; bus.MCU_WRQ = 1'b0; bus.MCU_ADDR = 24'd0; bus.MCU_DOUT = 8'd0;
      bus.MEM_DIN = 16'd0;

      // Reset values
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_strobes", {23'd0, strobes()}, {23'd0, 9'b11111_0000});
      check("reset_mem_a", {9'd0, bus.MEM_A}, 32'd0);
      check("reset_mem_dout", {16'd0, bus.MEM_DOUT}, 32'd0);
      check("reset_data_out", {16'd0, bus.SNES_DOUT, bus.MCU_DIN}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // SNES read, odd address -> high lane
      bus.MEM_DIN = 16'hA55A;
      snes_req(1'b1, 1'b0, 24'h000101, 8'h00, 1'b1, 1'b0, t);
      snes_q.push_back('{8'hA5, t + 8});
      check("srd_idle_at_t", {31'd0, bus.MEM_CE_N}, 32'd1);
      run_to(t + 1);
      check("srd_mem_a", {9'd0, bus.MEM_A}, 32'h80);
      check("srd_lanes_ce_oe", {28'd0, bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_BHE_N, bus.MEM_BLE_N}, 32'b0001);
      check("srd_busy", {31'd0, bus.BUSY}, 32'd1);
      run_to(t + 7);
      check("srd_ce_last_clock", {31'd0, bus.MEM_CE_N}, 32'd0);
      run_to(t + 8);
      check("srd_ce_released", {30'd0, bus.MEM_CE_N, bus.BUSY}, 32'b10);
      run_to(t + 12);

      // SNES write to save RAM
      snes_req(1'b0, 1'b1, 24'hE00000, 8'h3C, 1'b1, 1'b1, t);
      cnt = 0; cnt2 = 0; first_low = -1;
      for (int k = 1; k <= 10; k++) begin
         run_to(t + k);
         if (k == 1) begin
            check("swr_mem_dout", {16'd0, bus.MEM_DOUT}, 32'h3C3C);
            check("swr_mem_a", {9'd0, bus.MEM_A}, 32'h700000);
            check("swr_lanes_oe", {29'd0, bus.MEM_OE_N, bus.MEM_BHE_N, bus.MEM_BLE_N}, 32'b110);
         end
         if (!bus.MEM_WE_N) begin
            cnt++;
            if (first_low < 0) first_low = cyc;
         end
         if (bus.MEM_DOE) cnt2++;
      end
      check("swr_we_low_clocks", cnt, 5);
      check("swr_we_first_low", first_low, t + 2);
      check("swr_doe_clocks", cnt2, CL);

      // Ignored requests: non-writable write, read without ROM_HIT
      snes_req(1'b0, 1'b1, 24'hE00002, 8'h55, 1'b1, 1'b0, t);
      snes_req(1'b1, 1'b0, 24'h000200, 8'h00, 1'b0, 1'b0, t2);
      cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         run_to(t + k);
         if (bus.BUSY || !bus.MEM_CE_N || !bus.MEM_WE_N || bus.MEM_DOE) cnt++;
      end
      check("ignored_requests_activity", cnt, 0);

      // MCU read at t, SNES read at t+2: MCU first, one dead clock, then SNES
      bus.MEM_DIN = 16'h1234;
      mcu_req(1'b1, 24'h000010, 8'h00, t);
      snes_req(1'b1, 1'b0, 24'h000203, 8'h00, 1'b1, 1'b0, t2);
      check("arb_snes_pulse_cycle", t2, t + 2);
      mcu_q.push_back('{8'h34, t + 8});
      snes_q.push_back('{8'hBE, t + 17});
      run_to(t + 9);
      bus.MEM_DIN = 16'hBEEF;
      check("arb_gap_clock", {30'd0, bus.MEM_CE_N, bus.BUSY}, 32'b10);
      run_to(t + 10);
      check("arb_srd_start", {30'd0, bus.MEM_CE_N, bus.MEM_BHE_N}, 32'b00);
      check("arb_srd_mem_a", {9'd0, bus.MEM_A}, 32'h101);
      run_to(t + 20);

      // MCU write, odd address; MCU_DIN keeps the last read byte
      mcu_req(1'b0, 24'h000005, 8'h77, t);
      mcu_q.push_back('{8'h34, t + 8});
      run_to(t + 1);
      check("mwr_dout", {16'd0, bus.MEM_DOUT}, 32'h7777);
      check("mwr_lanes_doe", {29'd0, bus.MEM_BHE_N, bus.MEM_BLE_N, bus.MEM_DOE}, 32'b011);
      run_to(t + 2);
      check("mwr_we_low", {31'd0, bus.MEM_WE_N}, 32'd0);
      run_to(t + 12);

      // Read and write strobes in the same clock: only the read happens
      bus.MEM_DIN = 16'h5AC3;
      snes_req(1'b1, 1'b1, 24'hE00004, 8'hEE, 1'b1, 1'b1, t);
      snes_q.push_back('{8'hC3, t + 8});
      cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         run_to(t + k);
         if (!bus.MEM_WE_N || bus.MEM_DOE) cnt++;
      end
      check("rdwr_same_clock_no_write", cnt, 0);

      // Asynchronous reset during the fourth clock of a write
      mcu_req(1'b0, 24'h000002, 8'h11, t);
      run_to(t + 4);
      check("rst_mid_we_before", {31'd0, bus.MEM_WE_N}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_strobes", {23'd0, strobes()}, {23'd0, 9'b11111_0000});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      t = cyc;
      run_to(t + 12);   // any MCU_RDY here is flagged by the monitor

      // Fresh request after reset behaves as from reset
      bus.MEM_DIN = 16'h9911;
      snes_req(1'b1, 1'b0, 24'h000003, 8'h00, 1'b1, 1'b0, t);
      snes_q.push_back('{8'h99, t + 8});
      run_to(t + 1);
      check("post_rst_mem_a", {9'd0, bus.MEM_A}, 32'h1);
      run_to(t + 12);

      check("snes_responses_missing", snes_q.size(), 0);
      check("mcu_responses_missing", mcu_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
